lsu_align: RTL and testbench

Parametrised load/store unit sitting between the core's datapath and the data-memory request/response port. It accepts byte, half, word and, when XLEN=64, double accesses at any byte address. It generates aligned bus beats with byte-lane write masks, and splits an access that crosses a bus-word boundary into two beats. It returns a sign- or zero-extended load result or an error, replacing the core's direct lsu wiring, which handles only naturally aligned accesses.

---
 rtl/lsu_align.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lsu_align.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the core datapath and the
// data-memory port. It turns byte/half/word/double accesses at any byte
// address into bus-word-aligned beats with byte-lane masks, and splits an
// access that crosses a bus-word boundary into two beats separated by one
// idle cycle. Loads return sign- or zero-extended data, or an error.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   req_valid/req_ready       core request handshake (ready only in IDLE)
//   req_wen, req_addr,        store flag, byte address,
//   req_size, req_signed,     size code (0 B, 1 H, 2 W, 3 D), sign-extend flag,
//   req_wdata                 right-justified store data
//   resp_valid/err/rdata      one-cycle completion pulse with status and data
//   mem_reqValid, mem_addr,   bus request level and aligned address,
//   mem_wen, mem_wdata,       store beat flag, lane-positioned data,
//   mem_wmask                 byte enables (zero on loads)
//   mem_respValid, mem_rdata  one-cycle bus completion with the full bus word
module lsu_align #(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_reqValid,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic            mem_respValid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int B  = XLEN / 8;
    localparam int OB = $clog2(B);

    typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, DONE} state_e;

    // Byte-lane mask across two bus words: n ones shifted up by the offset.
    function automatic logic [2*B-1:0] lane_mask(input logic [OB-1:0] off,
                                                 input logic [1:0]    size);
        logic [2*B-1:0] ones;
        ones = '0;
        for (int i = 0; i < 2 * B; i++) begin
            if (i < (1 << size)) ones[i] = 1'b1;
        end
        return ones << off;
    endfunction

    // Right-justify the addressed bytes of {hi, lo} and extend to XLEN.
    // The field is pushed to the top and shifted back down, arithmetically
    // when signed; a field as wide as XLEN gets a zero shift (no extension).
    function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] pair,
                                                    input logic [OB-1:0]     off,
                                                    input logic [1:0]        size,
                                                    input logic              sgn);
        logic [2*XLEN-1:0]      sh;
        logic [XLEN-1:0]        up;
        logic signed [XLEN-1:0] tmp;
        logic [XLEN-1:0]        res;
        int                     nbits;
        int                     amt;
        sh    = pair >> {off, 3'b000};
        nbits = 8 << size;
        amt   = (nbits >= XLEN) ? 0 : XLEN - nbits;
        up    = sh[XLEN-1:0] << amt;
        if (sgn) begin
            tmp = $signed(up);
            tmp = tmp >>> amt;
            res = tmp;
        end else begin
            res = up >> amt;
        end
        return res;
    endfunction

    // Transaction state and latched request fields
    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        size_q, size_d;
    logic [OB-1:0]     off_q, off_d;
    logic              split_q, split_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic [2*XLEN-1:0] wdata2_q, wdata2_d;
    logic [2*B-1:0]    mask2_q, mask2_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   hi_q, hi_d;

    // Registered outputs
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              mem_reqValid_q, mem_reqValid_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [B-1:0]      mem_wmask_q, mem_wmask_d;

    logic              req_split;

    // Split when the access runs past the end of the bus word.
    always_comb begin
        req_split = (int'(req_addr[OB-1:0]) + (1 << req_size)) > B;
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        sgn_d    = sgn_q;
        size_d   = size_q;
        off_d    = off_q;
        split_d  = split_q;
        err_d    = err_q;
        base_d   = base_q;
        wdata2_d = wdata2_q;
        mask2_d  = mask2_q;
        lo_d     = lo_q;
        hi_d     = hi_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    sgn_d    = req_signed;
                    size_d   = req_size;
                    off_d    = req_addr[OB-1:0];
                    split_d  = req_split;
                    base_d   = {req_addr[XLEN-1:OB], {OB{1'b0}}};
                    wdata2_d = {{XLEN{1'b0}}, req_wdata} << {req_addr[OB-1:0], 3'b000};
                    mask2_d  = lane_mask(req_addr[OB-1:0], req_size);
                    lo_d     = '0;
                    hi_d     = '0;
                    err_d    = (req_size == 2'd3 && XLEN == 32) ||
                               (req_split && !MISALIGN_SPLIT);
                    state_d  = err_d ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                if (mem_respValid) begin
                    lo_d    = mem_rdata;
                    state_d = split_q ? GAP : DONE;
                end
            end
            GAP: state_d = BEAT1;
            BEAT1: begin
                if (mem_respValid) begin
                    hi_d    = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, derived from the next state so every output is a flop
    always_comb begin
        req_ready_d    = (state_d == IDLE);
        resp_valid_d   = (state_d == DONE);
        resp_err_d     = (state_d == DONE) && err_d;
        resp_rdata_d   = '0;
        mem_reqValid_d = 1'b0;
        mem_addr_d     = '0;
        mem_wen_d      = 1'b0;
        mem_wdata_d    = '0;
        mem_wmask_d    = '0;

        if (state_d == DONE && !err_d && !wen_d) begin
            resp_rdata_d = load_extend({hi_d, lo_d}, off_d, size_d, sgn_d);
        end

        if (state_d == BEAT0) begin
            mem_reqValid_d = 1'b1;
            mem_addr_d     = base_d;
            mem_wen_d      = wen_d;
            if (wen_d) begin
                mem_wdata_d = wdata2_d[XLEN-1:0];
                mem_wmask_d = mask2_d[B-1:0];
            end
        end else if (state_d == BEAT1) begin
            mem_reqValid_d = 1'b1;
            mem_addr_d     = base_d + XLEN'(B);
            mem_wen_d      = wen_d;
            if (wen_d) begin
                mem_wdata_d = wdata2_d[2*XLEN-1:XLEN];
                mem_wmask_d = mask2_d[2*B-1:B];
            end
        end
    end

    // Stage boundary: all state and outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            wen_q          <= 1'b0;
            sgn_q          <= 1'b0;
            size_q         <= '0;
            off_q          <= '0;
            split_q        <= 1'b0;
            err_q          <= 1'b0;
            base_q         <= '0;
            wdata2_q       <= '0;
            mask2_q        <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= '0;
            mem_reqValid_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            mem_wmask_q    <= '0;
        end else begin
            state_q        <= state_d;
            wen_q          <= wen_d;
            sgn_q          <= sgn_d;
            size_q         <= size_d;
            off_q          <= off_d;
            split_q        <= split_d;
            err_q          <= err_d;
            base_q         <= base_d;
            wdata2_q       <= wdata2_d;
            mask2_q        <= mask2_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            mem_reqValid_q <= mem_reqValid_d;
            mem_addr_q     <= mem_addr_d;
            mem_wen_q      <= mem_wen_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wmask_q    <= mem_wmask_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign mem_reqValid = mem_reqValid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wen      = mem_wen_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wmask    = mem_wmask_q;

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align at XLEN=32: a table of accesses with hand-computed
// bus beats and results, a response scoreboard, plus hand-written sequences
// for reset during a split access and the no-split error configuration.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        reset;

    // DUT with splitting enabled
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_reqValid, mem_wen, mem_respValid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // DUT with splitting disabled
    logic        req_valid2, req_ready2, req_wen2, req_signed2;
    logic [31:0] req_addr2, req_wdata2;
    logic [1:0]  req_size2;
    logic        resp_valid2, resp_err2;
    logic [31:0] resp_rdata2;
    logic        mem_reqValid2, mem_wen2, mem_respValid2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;
    logic [3:0]  mem_wmask2;

    int checks   = 0;
    int failures = 0;
    int cur_vec  = -1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] r0;
        logic [31:0] r1;
        int          d0;
        logic        split;
        logic        err;
        logic [31:0] a0;
        logic [3:0]  m0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  m1;
        logic [31:0] w1;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    lsu_align #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut (
        .clock(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
    );

    lsu_align #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut2 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wen(req_wen2),
        .req_addr(req_addr2), .req_size(req_size2), .req_signed(req_signed2),
        .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_err(resp_err2), .resp_rdata(resp_rdata2),
        .mem_reqValid(mem_reqValid2), .mem_addr(mem_addr2), .mem_wen(mem_wen2),
        .mem_wdata(mem_wdata2), .mem_wmask(mem_wmask2),
        .mem_respValid(mem_respValid2), .mem_rdata(mem_rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp (vec %0d): got resp_valid=1 required no response", cur_vec);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", resp_err, e.err);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_reqValid", mem_reqValid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
    endtask

    task automatic drive_req(input vec_t v);
        req_valid  = 1'b1;
        req_wen    = v.wen;
        req_addr   = v.addr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_wdata  = v.wdata;
    endtask

    task automatic scramble_req();
        req_valid  = 1'b0;
        req_wen    = 1'($urandom);
        req_addr   = $urandom;
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_wdata  = $urandom;
    endtask

    task automatic run_vec(input vec_t v);
        chk("req_ready_before", req_ready, 1);
        drive_req(v);
        sb.push_back('{v.rdata, v.err});
        cycle();
        scramble_req();
        if (v.err) begin
            chk("err_no_bus", mem_reqValid, 0);
            chk("err_resp_valid", resp_valid, 1);
            cycle();
            chk("err_ready_back", req_ready, 1);
            chk("err_no_bus_after", mem_reqValid, 0);
            return;
        end
        chk("b0_reqValid", mem_reqValid, 1);
        chk("b0_addr", mem_addr, v.a0);
        chk("b0_wen", mem_wen, v.wen);
        chk("b0_wmask", mem_wmask, v.m0);
        chk("b0_wdata", mem_wdata, v.w0);
        for (int i = 0; i < v.d0; i++) begin
            cycle();
            chk("b0_hold_reqValid", mem_reqValid, 1);
            chk("b0_hold_addr", mem_addr, v.a0);
            chk("b0_hold_wmask", mem_wmask, v.m0);
            chk("b0_hold_wdata", mem_wdata, v.w0);
        end
        mem_respValid = 1'b1;
        mem_rdata     = v.r0;
        cycle();
        mem_respValid = 1'b0;
        mem_rdata     = $urandom;
        if (v.split) begin
            chk("gap_reqValid", mem_reqValid, 0);
            chk("gap_resp_valid", resp_valid, 0);
            cycle();
            chk("b1_reqValid", mem_reqValid, 1);
            chk("b1_addr", mem_addr, v.a1);
            chk("b1_wen", mem_wen, v.wen);
            chk("b1_wmask", mem_wmask, v.m1);
            chk("b1_wdata", mem_wdata, v.w1);
            mem_respValid = 1'b1;
            mem_rdata     = v.r1;
            cycle();
            mem_respValid = 1'b0;
            mem_rdata     = $urandom;
        end
        chk("done_resp_valid", resp_valid, 1);
        chk("done_reqValid", mem_reqValid, 0);
        chk("done_not_ready", req_ready, 0);
        cycle();
        chk("idle_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        //          wen   addr          sz    sgn   wdata         r0            r1            d0 spl   err   a0            m0       w0            a1            m1       w1            rdata
        vecs[0]  = '{1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h1111_2222, 32'h80AA_BBCC, 32'h0,        0, 1'b0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'h1234_5678, 32'h0,        0, 1'b0, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 32'h0000_3003, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h4433_2211, 32'h8877_6655, 0, 1'b1, 1'b0, 32'h0000_3000, 4'b0000, 32'h0,        32'h0000_3004, 4'b0000, 32'h0,        32'h7766_5544};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'hDDCC_BBAA, 32'h0,        32'h0,        1, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'hBBAA_0000, 32'h0000_0000, 4'b0011, 32'h0000_DDCC, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0040, 2'd3, 1'b1, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, 32'h0000_4001, 2'd1, 1'b0, 32'h0,        32'hA1B2_C3D4, 32'h0,        0, 1'b0, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_B2C3};
        vecs[6]  = '{1'b0, 32'h0000_4001, 2'd1, 1'b1, 32'h0,        32'hA1B2_C3D4, 32'h0,        0, 1'b0, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_B2C3};
        vecs[7]  = '{1'b0, 32'h0000_5003, 2'd1, 1'b1, 32'h0,        32'h1122_3344, 32'hAABB_CC80, 2, 1'b1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_5004, 4'b0000, 32'h0,        32'hFFFF_8011};
        vecs[8]  = '{1'b1, 32'h0000_6001, 2'd0, 1'b0, 32'h0000_005A, 32'h0,        32'h0,        0, 1'b0, 1'b0, 32'h0000_6000, 4'b0010, 32'h0000_5A00, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 32'h0000_7000, 2'd2, 1'b1, 32'h0,        32'h8000_0001, 32'h0,        2, 1'b0, 1'b0, 32'h0000_7000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h8000_0001};
        vecs[10] = '{1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0,        32'h80AA_BBCC, 32'h0,        0, 1'b0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0080};
        vecs[11] = '{1'b1, 32'h0000_7FFF, 2'd1, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0000_7FFC, 4'b1000, 32'h3400_0000, 32'h0000_8000, 4'b0001, 32'h0000_0012, 32'h0};

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_wen        = 1'b0;
        req_addr       = '0;
        req_size       = '0;
        req_signed     = 1'b0;
        req_wdata      = '0;
        mem_respValid  = 1'b0;
        mem_rdata      = '0;
        req_valid2     = 1'b0;
        req_wen2       = 1'b0;
        req_addr2      = '0;
        req_size2      = '0;
        req_signed2    = 1'b0;
        req_wdata2     = '0;
        mem_respValid2 = 1'b0;
        mem_rdata2     = '0;

        cycle();
        cycle();
        check_reset_outputs();
        chk("rst_ready2", req_ready2, 1);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < NV; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Reset during GAP of a split load, then a stray bus pulse.
        cur_vec = 100;
        drive_req(vecs[2]);
        cycle();
        scramble_req();
        chk("rg_b0_reqValid", mem_reqValid, 1);
        mem_respValid = 1'b1;
        mem_rdata     = vecs[2].r0;
        cycle();
        mem_respValid = 1'b0;
        chk("rg_gap_reqValid", mem_reqValid, 0);
        reset = 1'b1;
        cycle();
        check_reset_outputs();
        reset = 1'b0;
        mem_respValid = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        cycle();
        mem_respValid = 1'b0;
        check_reset_outputs();
        cycle();
        check_reset_outputs();
        cur_vec = 101;
        run_vec(vecs[0]);

        // No-split configuration: crossing word load is an error, no bus traffic.
        cur_vec       = 200;
        req_valid2    = 1'b1;
        req_wen2      = 1'b0;
        req_addr2     = 32'h0000_0011;
        req_size2     = 2'd2;
        req_signed2   = 1'b0;
        req_wdata2    = 32'h5555_AAAA;
        cycle();
        req_valid2    = 1'b0;
        req_addr2     = 32'h0;
        chk("ns_resp_valid", resp_valid2, 1);
        chk("ns_resp_err", resp_err2, 1);
        chk("ns_resp_rdata", resp_rdata2, 0);
        chk("ns_reqValid", mem_reqValid2, 0);
        cycle();
        chk("ns_ready_back", req_ready2, 1);
        chk("ns_resp_valid_off", resp_valid2, 0);
        chk("ns_reqValid_after", mem_reqValid2, 0);

        cycle();
        cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending responses required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
